q_redis_row_seq: RTL

Row-drive sequencer for the charge-redistribution CIM macro. It accepts one binary activation bit-plane per handshake. For each plane it emits a registered, break-before-make sequence on the array's row and phase controls: reset, drive, then sense. It sits directly upstream of the macro's row drivers and replaces the free-running stimulus used in macro-level characterisation.

---
 rtl/q_redis_pkg.sv | 19 +
 rtl/q_redis_phase_timer.sv | 22 ++
 rtl/q_redis_row_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/q_redis_pkg.sv
// Shared types and defaults for the charge-redistribution row-drive sequencer.
package q_redis_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    GAP0,
    DRIVE,
    GAP1,
    SENSE
  } qr_state_e;

  localparam int T_RST_DEF = 4;
  localparam int T_DRV_DEF = 4;
  localparam int T_SA_DEF  = 2;
  localparam int PIDX_W    = 8;
  localparam int CNT_W     = 8;

endpackage

// File: rtl/q_redis_phase_timer.sv
// Loadable down-counter; zero is high once the loaded count has elapsed.
module q_redis_phase_timer #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)              cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/q_redis_row_seq.sv
// Row-drive sequencer: reset / drive / sense per activation plane, break-before-make.
// Optional row masking is enabled with `define QR_ROW_MASK_EN.
module q_redis_row_seq
  import q_redis_pkg::*;
#(
  parameter int SRAM_ROWS = 128,
  parameter int T_RST     = T_RST_DEF,
  parameter int T_DRV     = T_DRV_DEF,
  parameter int T_SA      = T_SA_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SRAM_ROWS-1:0] in_plane,
  input  logic                 in_neg,
  input  logic                 in_last,
`ifdef QR_ROW_MASK_EN
  input  logic [SRAM_ROWS-1:0] row_mask,
`endif
  output logic [SRAM_ROWS-1:0] VDR_SEL,
  output logic [SRAM_ROWS-1:0] VDR_SELB,
  output logic [SRAM_ROWS-1:0] VSS_SEL,
  output logic [SRAM_ROWS-1:0] VSS_SELB,
  output logic [SRAM_ROWS-1:0] VRST_SEL,
  output logic [SRAM_ROWS-1:0] VRST_SELB,
  output logic                 NF,
  output logic                 NFB,
  output logic                 M2A,
  output logic                 M2AB,
  output logic                 R2A,
  output logic                 R2AB,
  output logic                 PCH,
  output logic                 SAEN,
  output logic [PIDX_W-1:0]    plane_idx,
  output logic                 done
);

  qr_state_e            state, nxt;
  logic                 accept, fin, fin_q, tmr_zero, ld;
  logic [CNT_W-1:0]     ld_val;
  logic [SRAM_ROWS-1:0] plane_q, mask_q;
  logic                 neg_q, last_q;
  logic [SRAM_ROWS-1:0] vdr_d, vss_d, vrst_d;
  logic                 nf_d, m2a_d, r2a_d, pch_d, saen_d;

  assign accept = (state == IDLE) & in_valid & in_ready;
  assign fin    = (state == SENSE) & tmr_zero;

  q_redis_phase_timer #(.W(CNT_W)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (ld),
    .load_val (ld_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    nxt    = state;
    ld     = 1'b0;
    ld_val = '0;
    unique case (state)
      IDLE:  if (accept) begin nxt = RESET; ld = 1'b1; ld_val = CNT_W'(T_RST - 1); end
      RESET: if (tmr_zero) nxt = GAP0;
      GAP0:  begin nxt = DRIVE; ld = 1'b1; ld_val = CNT_W'(T_DRV - 1); end
      DRIVE: if (tmr_zero) nxt = GAP1;
      GAP1:  begin nxt = SENSE; ld = 1'b1; ld_val = CNT_W'(T_SA - 1); end
      SENSE: if (tmr_zero) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Row/phase values derived from the current state; registered below so the
  // pins lag the state by one cycle and never see a combinational input path.
  always_comb begin
    vdr_d  = '0;
    vss_d  = '0;
    vrst_d = '0;
    nf_d   = 1'b0;
    m2a_d  = 1'b0;
    r2a_d  = 1'b0;
    pch_d  = 1'b0;
    saen_d = 1'b0;
    unique case (state)
      RESET: begin vrst_d = '1; r2a_d = 1'b1; pch_d = 1'b1; end
      DRIVE: begin
        m2a_d = 1'b1;
        nf_d  = neg_q;
        vdr_d = (neg_q ? ~plane_q : plane_q) & ~mask_q;
        vss_d = (neg_q ? plane_q : ~plane_q) & ~mask_q;
      end
      SENSE: saen_d = 1'b1;
      default: ;
    endcase
    // Masked rows stay parked on the reset rail for the whole plane.
    if (state != IDLE) vrst_d = vrst_d | mask_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      plane_q   <= '0;
      neg_q     <= 1'b0;
      last_q    <= 1'b0;
      fin_q     <= 1'b0;
      done      <= 1'b0;
      plane_idx <= '0;
      VDR_SEL   <= '0;
      VSS_SEL   <= '0;
      VRST_SEL  <= '0;
      NF        <= 1'b0;
      M2A       <= 1'b0;
      R2A       <= 1'b0;
      PCH       <= 1'b0;
      SAEN      <= 1'b0;
    end else begin
      state    <= nxt;
      in_ready <= (nxt == IDLE);
      if (accept) begin
        plane_q <= in_plane;
        neg_q   <= in_neg;
        last_q  <= in_last;
      end
      fin_q <= fin;
      done  <= fin_q & last_q;
      if (fin_q) plane_idx <= last_q ? '0 : ((&plane_idx) ? plane_idx : plane_idx + 1'b1);
      VDR_SEL  <= vdr_d;
      VSS_SEL  <= vss_d;
      VRST_SEL <= vrst_d;
      NF       <= nf_d;
      M2A      <= m2a_d;
      R2A      <= r2a_d;
      PCH      <= pch_d;
      SAEN     <= saen_d;
    end
  end

`ifdef QR_ROW_MASK_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         mask_q <= '0;
    else if (accept) mask_q <= row_mask;
  end
`else
  assign mask_q = '0;
`endif

  assign VDR_SELB  = ~VDR_SEL;
  assign VSS_SELB  = ~VSS_SEL;
  assign VRST_SELB = ~VRST_SEL;
  assign NFB       = ~NF;
  assign M2AB      = ~M2A;
  assign R2AB      = ~R2A;

endmodule
